// File: rtl/siso_pkg.sv
// Shared definitions for the soft-output RSC encoder: amplitude default,
// encoder FSM states, tail length and the bit-to-symbol mapping.
package siso_pkg;

   localparam logic [15:0] AMP_DEFAULT = 16'h0040;
   localparam int          TAIL_LEN    = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_EMIT_PAR,
      ST_TAIL_SYS,
      ST_TAIL_PAR
   } enc_state_e;

   // bit 0 -> +amp, bit 1 -> -amp (two's complement)
   function automatic logic [15:0] map_symbol(input logic b, input logic [15:0] amp);
      return b ? (~amp + 16'd1) : amp;
   endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// One step of the LTE RSC constituent code (feedback 1+D2+D3, parity 1+D+D3).
// state[0]=s0 (D1), state[1]=s1 (D2), state[2]=s2 (D3).
module rsc_trellis_step (
   input  logic       u,
   input  logic [2:0] state,
   input  logic       tail,
   output logic [2:0] next_state,
   output logic       sys_bit,
   output logic       par_bit
);

   logic u_eff;
   logic a;

   always_comb begin
      // during termination the input cancels the feedback so a is forced to 0
      u_eff      = tail ? (state[1] ^ state[2]) : u;
      a          = u_eff ^ state[1] ^ state[2];
      sys_bit    = u_eff;
      par_bit    = a ^ state[0] ^ state[2];
      next_state = {state[1], state[0], a};
   end

endmodule

// File: rtl/rsc_encoder.sv
// RSC encoder emitting an interleaved sys/parity soft-symbol stream per frame,
// followed by three trellis-terminating tail steps.
//
// state        | meaning
// ST_IDLE      | waiting for start with a non-zero blklen
// ST_ACCEPT    | ready_in high, waiting for valid_in to take an info bit
// ST_EMIT_PAR  | emit parity of the bit just accepted
// ST_TAIL_SYS  | emit tail systematic bit, advance trellis toward 000
// ST_TAIL_PAR  | emit tail parity; last_out on the third tail step
module rsc_encoder
   import siso_pkg::*;
#(
   parameter logic [15:0] AMP = AMP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] blklen,
   input  logic        bit_in,
   input  logic        valid_in,
   output logic        ready_in,
   output logic [15:0] out,
   output logic        valid_out,
   output logic        last_out,
   output logic        busy
);

   enc_state_e  state_q, state_d;
   logic [2:0]  trel_q, trel_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] blklen_q, blklen_d;
   logic [1:0]  tail_q, tail_d;
   logic        par_q, par_d;
   logic [15:0] out_q, out_d;
   logic        valid_out_q, valid_out_d;
   logic        last_out_q, last_out_d;

   logic [2:0]  step_next;
   logic        step_sys;
   logic        step_par;
   logic        step_tail;

   assign step_tail = (state_q == ST_TAIL_SYS);

   rsc_trellis_step u_step (
      .u          (bit_in),
      .state      (trel_q),
      .tail       (step_tail),
      .next_state (step_next),
      .sys_bit    (step_sys),
      .par_bit    (step_par)
   );

   always_comb begin
      state_d     = state_q;
      trel_d      = trel_q;
      cnt_d       = cnt_q;
      blklen_d    = blklen_q;
      tail_d      = tail_q;
      par_d       = par_q;
      out_d       = out_q;
      valid_out_d = 1'b0;
      last_out_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && (blklen != 16'd0)) begin
               blklen_d = blklen;
               trel_d   = 3'b000;
               cnt_d    = 16'd0;
               tail_d   = 2'd0;
               state_d  = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            if (valid_in) begin
               out_d       = map_symbol(step_sys, AMP);
               valid_out_d = 1'b1;
               par_d       = step_par;
               trel_d      = step_next;
               cnt_d       = cnt_q + 16'd1;
               state_d     = ST_EMIT_PAR;
            end
         end
         ST_EMIT_PAR: begin
            out_d       = map_symbol(par_q, AMP);
            valid_out_d = 1'b1;
            state_d     = (cnt_q == blklen_q) ? ST_TAIL_SYS : ST_ACCEPT;
         end
         ST_TAIL_SYS: begin
            out_d       = map_symbol(step_sys, AMP);
            valid_out_d = 1'b1;
            par_d       = step_par;
            trel_d      = step_next;
            state_d     = ST_TAIL_PAR;
         end
         ST_TAIL_PAR: begin
            out_d       = map_symbol(par_q, AMP);
            valid_out_d = 1'b1;
            if (tail_q == 2'(TAIL_LEN - 1)) begin
               last_out_d = 1'b1;
               tail_d     = 2'd0;
               state_d    = ST_IDLE;
            end else begin
               tail_d  = tail_q + 2'd1;
               state_d = ST_TAIL_SYS;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         trel_q      <= 3'b000;
         cnt_q       <= 16'd0;
         blklen_q    <= 16'd0;
         tail_q      <= 2'd0;
         par_q       <= 1'b0;
         out_q       <= 16'd0;
         valid_out_q <= 1'b0;
         last_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         trel_q      <= trel_d;
         cnt_q       <= cnt_d;
         blklen_q    <= blklen_d;
         tail_q      <= tail_d;
         par_q       <= par_d;
         out_q       <= out_d;
         valid_out_q <= valid_out_d;
         last_out_q  <= last_out_d;
      end
   end

   assign ready_in  = (state_q == ST_ACCEPT);
   assign busy      = (state_q != ST_IDLE);
   assign out       = out_q;
   assign valid_out = valid_out_q;
   assign last_out  = last_out_q;

endmodule

// File: doc/rsc_encoder.md
RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 Parameter AMP, default 16'h0040, magnitude of the emitted soft symbol.
REQ-002 clk  in  1  sole clock, all logic on posedge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  frame start pulse, sampled in IDLE only.
REQ-005 blklen  in  16  info bits per frame, sampled with start.
REQ-006 bit_in  in  1  info bit.
REQ-007 valid_in  in  1  bit_in qualifier.
REQ-008 ready_in  out  1  encoder accepts bit_in this cycle.
REQ-009 out  out  16  signed soft symbol, interleaved sys/parity stream.
REQ-010 valid_out  out  1  out qualifier.
REQ-011 last_out  out  1  marks final symbol of frame.
REQ-012 busy  out  1  frame in progress (any state except IDLE).

Function
REQ-013 Constituent code SHALL be LTE RSC, feedback 1+D2+D3, parity 1+D+D3; state s0=D1, s1=D2, s2=D3.
REQ-014 Per step: a = u^s1^s2; parity = a^s0^s2; next state (s0,s1,s2) = (a,s0,s1).
REQ-015 Mapping SHALL be bit 0 -> +AMP, bit 1 -> -AMP (two's complement, 16 bit).
REQ-016 FSM states: IDLE, ACCEPT, EMIT_PAR, TAIL_SYS, TAIL_PAR.
REQ-017 IDLE: start=1 and blklen!=0 -> latch blklen, clear trellis state and bit counter, go ACCEPT; start with blklen=0 ignored.
REQ-018 ACCEPT: ready_in=1; on valid_in=1 register sys symbol (map of u) to out with valid_out=1 next cycle, update trellis, go EMIT_PAR.
REQ-019 EMIT_PAR: ready_in=0; out=parity symbol, valid_out=1; next ACCEPT, or TAIL_SYS when blklen bits accepted.
REQ-020 Throughput: one info bit per 2 cycles max; sys symbol 1 cycle after acceptance, parity symbol 2 cycles after.
REQ-021 Tail: 3 steps, u = s1^s2 (forces a=0); each step emits sys (tail bit) then parity, via TAIL_SYS/TAIL_PAR.
REQ-022 Trellis state SHALL be 000 after third tail step.
REQ-023 Frame SHALL emit exactly 2*(blklen+3) symbols; last_out=1 with the final tail parity only; then IDLE.
REQ-024 valid_out=0 and out held at last value during gaps (ACCEPT without valid_in).
REQ-025 start while busy SHALL be ignored; valid_in outside ACCEPT ignored.
REQ-026 No output backpressure; downstream always accepts.
REQ-027 Bit counter 16 bit; blklen=65535 SHALL complete without wrap error.

Reset
REQ-028 rst=0 at any clk edge, including mid-frame, SHALL force IDLE, trellis 000, counters 0, out=0, valid_out=0, last_out=0, ready_in=0, busy=0.
REQ-029 First start accepted on first edge after rst returns high.

Structure
REQ-030 Shared package siso_pkg SHALL hold AMP default, FSM state enum, TAIL_LEN=3.
REQ-031 One combinational sub-module rsc_trellis_step: inputs u, state, tail flag; outputs next state, sys bit, parity bit.

Verification
REQ-032 blklen=1, bit 0 -> 8 symbols all 16'h0040, last_out on 8th.
REQ-033 blklen=1, bit 1 -> FFC0,FFC0,0040,FFC0,FFC0,0040,FFC0,FFC0; final state 000.
REQ-034 blklen=40 random bits vs golden model -> 86 symbols match, valid_in gaps produce valid_out gaps only.
REQ-035 rst low mid-frame (after 5 bits) -> next cycle all outputs 0, IDLE; new frame encodes from state 000.
REQ-036 start with blklen=0, and start while busy -> ignored, stream unchanged.
